// File: rtl/mlab_scfifo_ctrl_pkg.sv
// Shared constants and helpers for the MLAB-based show-ahead FIFO.
package scfifo_pkg;

    localparam string FAMILY_AGILEX = "Agilex";
    localparam string FAMILY_S10    = "S10";
    localparam string FAMILY_OTHER  = "Other";

    // S10 MLABs register din internally, so a write lands one edge later.
    function automatic int write_lag(input string family);
        return (family == FAMILY_S10) ? 2 : 1;
    endfunction

    // Pointer width: addresses the MLAB directly and wraps mod DEPTH.
    function automatic int ptr_width(input int addr_width);
        return addr_width;
    endfunction

    // Count width: must hold 0..DEPTH inclusive.
    function automatic int cnt_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/mlab_scfifo_ctrl_if.sv
// Producer/consumer bus of the show-ahead FIFO.
//
// Handshake: a word is written when push=1 and full=0 at a rising edge
// (push while full is dropped). The head word is on rdata whenever
// empty=0 and stays stable until pop=1 at a rising edge consumes it;
// pop while empty=1 is ignored. full, empty and used are registered.
interface mlab_scfifo_ctrl_if #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 5
);
    logic                  push;
    logic [WIDTH-1:0]      wdata;
    logic                  full;
    logic                  pop;
    logic [WIDTH-1:0]      rdata;
    logic                  empty;
    logic [ADDR_WIDTH:0]   used;

    modport master (output push, wdata, pop, input full, rdata, empty, used);
    modport slave  (input push, wdata, pop, output full, rdata, empty, used);
endinterface

// File: rtl/mlab_scfifo_ctrl_mlab.sv
// Behavioural simple-dual-port MLAB: registered read, optional input
// register stage on the write side for the S10 family.
module generic_mlab_sc
    import scfifo_pkg::*;
#(
    parameter int    WIDTH      = 8,
    parameter int    ADDR_WIDTH = 5,
    parameter string FAMILY     = "Other"
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      din,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]      dout
);
    logic [WIDTH-1:0]      mem [1 << ADDR_WIDTH];
    logic                  we_w;
    logic [ADDR_WIDTH-1:0] waddr_w;
    logic [WIDTH-1:0]      din_w;
    logic [WIDTH-1:0]      dout_q;
    logic [WIDTH-1:0]      dout_d;

    if (FAMILY == FAMILY_S10) begin : g_in_reg
        logic                  we_q;
        logic [ADDR_WIDTH-1:0] waddr_q;
        logic [WIDTH-1:0]      din_q;

        // S10: write port is registered once before reaching the array.
        always_ff @(posedge clk) begin
            we_q    <= we;
            waddr_q <= waddr;
            din_q   <= din;
        end

        assign we_w    = we_q;
        assign waddr_w = waddr_q;
        assign din_w   = din_q;
    end else begin : g_no_reg
        assign we_w    = we;
        assign waddr_w = waddr;
        assign din_w   = din;
    end

    // Array write; contents are never cleared.
    always_ff @(posedge clk) begin
        if (we_w) begin
            mem[waddr_w] <= din_w;
        end
    end

    // Output register loads only on a read enable, otherwise holds.
    always_comb begin
        dout_d = dout_q;
        if (re) begin
            dout_d = mem[raddr];
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        dout_q <= dout_d;
    end

    assign dout = dout_q;

endmodule

// File: rtl/mlab_scfifo_ctrl.sv
// Show-ahead single-clock FIFO controller around one generic_mlab_sc.
// Hides the MLAB read register and the family write lag so the head word
// is always on rdata while empty is low.
module mlab_scfifo_ctrl
    import scfifo_pkg::*;
#(
    parameter int    WIDTH      = 8,
    parameter int    ADDR_WIDTH = 5,
    parameter string FAMILY     = "Other"
) (
    input  logic               clk,
    input  logic               rst_n,
    mlab_scfifo_ctrl_if.slave  bus
);
    localparam int DEPTH     = 1 << ADDR_WIDTH;
    localparam int WRITE_LAG = write_lag(FAMILY);
    localparam int PW        = ptr_width(ADDR_WIDTH);
    localparam int CW        = cnt_width(ADDR_WIDTH);

    logic [PW-1:0]        wptr_q, wptr_d;
    logic [PW-1:0]        rptr_q, rptr_d;
    logic [CW-1:0]        used_q, used_d;
    logic [CW-1:0]        avail_q, avail_d;
    logic [WRITE_LAG-1:0] pdly_q, pdly_d;
    logic                 out_valid_q, out_valid_d;
    logic                 empty_q, empty_d;
    logic                 full_q, full_d;
    logic                 push_acc;
    logic                 pop_acc;
    logic                 re;
    logic [WIDTH-1:0]     mlab_dout;

    // Next-state for pointers, counts, push-delay line and output flags.
    always_comb begin
        push_acc = bus.push & ~full_q;
        pop_acc  = bus.pop & out_valid_q;
        // Fetch the next word when one is readable and the output slot
        // is free or being vacated this cycle.
        re       = (avail_q != '0) & (~out_valid_q | pop_acc);

        wptr_d      = wptr_q + PW'(push_acc);
        rptr_d      = rptr_q + PW'(re);
        // Delay line: MSB is the push from WRITE_LAG edges ago.
        pdly_d      = WRITE_LAG'({pdly_q, push_acc});
        avail_d     = avail_q + CW'(pdly_q[WRITE_LAG-1]) - CW'(re);
        used_d      = used_q + CW'(push_acc) - CW'(pop_acc);
        out_valid_d = re | (out_valid_q & ~pop_acc);
        empty_d     = ~out_valid_d;
        full_d      = (used_d == CW'(DEPTH));
    end

    // Controller state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            used_q      <= '0;
            avail_q     <= '0;
            pdly_q      <= '0;
            out_valid_q <= 1'b0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            used_q      <= used_d;
            avail_q     <= avail_d;
            pdly_q      <= pdly_d;
            out_valid_q <= out_valid_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
        end
    end

    generic_mlab_sc #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .FAMILY     (FAMILY)
    ) u_mlab (
        .clk   (clk),
        .we    (push_acc),
        .waddr (wptr_q),
        .din   (bus.wdata),
        .re    (re),
        .raddr (rptr_q),
        .dout  (mlab_dout)
    );

    assign bus.rdata = mlab_dout;
    assign bus.empty = empty_q;
    assign bus.full  = full_q;
    assign bus.used  = used_q;

    a_used_max : assert property (@(posedge clk) disable iff (!rst_n)
        used_q <= CW'(DEPTH));
    a_avail_le_used : assert property (@(posedge clk) disable iff (!rst_n)
        (int'(avail_q) + int'(out_valid_q)) <= int'(used_q));
    a_no_same_addr : assert property (@(posedge clk) disable iff (!rst_n)
        !(re && push_acc && (rptr_q == wptr_q)));

endmodule

// File: tb/tb_mlab_scfifo_ctrl.sv
// Bench for mlab_scfifo_ctrl: one "Other" and one "S10" instance driven
// with identical stimulus, checked against a queue-based model and a
// table of hand-derived vectors.
module tb_mlab_scfifo_ctrl;

    localparam int W     = 8;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    int   edge_n;

    mlab_scfifo_ctrl_if #(.WIDTH(W), .ADDR_WIDTH(AW)) bus_o ();
    mlab_scfifo_ctrl_if #(.WIDTH(W), .ADDR_WIDTH(AW)) bus_s ();

    mlab_scfifo_ctrl #(.WIDTH(W), .ADDR_WIDTH(AW), .FAMILY("Other")) dut_o (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_o.slave)
    );

    mlab_scfifo_ctrl #(.WIDTH(W), .ADDR_WIDTH(AW), .FAMILY("S10")) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s.slave)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    // Reference model: words waiting in a queue with the edge at which they
    // first may become head; a separate head slot. Index 0 = Other, 1 = S10.
    typedef struct {
        logic [W-1:0] data;
        int           ready;
    } entry_t;

    entry_t       exp_q0[$];
    entry_t       exp_q1[$];
    bit           hv[2];
    logic [W-1:0] hd[2];

    function automatic int m_size(input int m);
        return (m == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic int m_used(input int m);
        return m_size(m) + int'(hv[m]);
    endfunction

    task automatic model_reset();
        exp_q0.delete();
        exp_q1.delete();
        hv[0] = 1'b0;
        hv[1] = 1'b0;
    endtask

    task automatic model_edge(input int m, input bit p, input logic [W-1:0] d, input bit q, input int n);
        int     lag;
        bit     push_ok;
        entry_t e;
        lag     = (m == 0) ? 1 : 2;
        push_ok = p && (m_used(m) != DEPTH);
        if (q && hv[m]) hv[m] = 1'b0;
        if (!hv[m] && m_size(m) > 0) begin
            e = (m == 0) ? exp_q0[0] : exp_q1[0];
            if (e.ready <= n) begin
                hv[m] = 1'b1;
                hd[m] = e.data;
                if (m == 0) void'(exp_q0.pop_front());
                else        void'(exp_q1.pop_front());
            end
        end
        if (push_ok) begin
            e.data  = d;
            e.ready = n + lag + 1;
            if (m == 0) exp_q0.push_back(e);
            else        exp_q1.push_back(e);
        end
    endtask

    // Scoreboard compare.
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic check_model();
        chk("o_empty", 32'(bus_o.empty), 32'(!hv[0]));
        chk("o_full",  32'(bus_o.full),  32'(m_used(0) == DEPTH));
        chk("o_used",  32'(bus_o.used),  32'(m_used(0)));
        if (hv[0]) chk("o_rdata", 32'(bus_o.rdata), 32'(hd[0]));
        chk("s_empty", 32'(bus_s.empty), 32'(!hv[1]));
        chk("s_full",  32'(bus_s.full),  32'(m_used(1) == DEPTH));
        chk("s_used",  32'(bus_s.used),  32'(m_used(1)));
        if (hv[1]) chk("s_rdata", 32'(bus_s.rdata), 32'(hd[1]));
    endtask

    // Driver: called at a falling edge; applies inputs over one rising edge.
    task automatic step(input bit p, input logic [W-1:0] d, input bit q);
        bus_o.push = p; bus_o.wdata = d; bus_o.pop = q;
        bus_s.push = p; bus_s.wdata = d; bus_s.pop = q;
        @(posedge clk);
        edge_n++;
        model_edge(0, p, d, q, edge_n);
        model_edge(1, p, d, q, edge_n);
        @(negedge clk);
        check_model();
    endtask

    typedef struct {
        bit           push;
        logic [W-1:0] wdata;
        bit           pop;
        bit           e_o;
        bit           e_s;
        logic [AW:0]  used;
        logic [W-1:0] rd;
    } vec_t;

    vec_t vecs[11];

    initial begin
        logic [W-1:0] prev_o;
        logic [W-1:0] prev_s;
        int           ko;
        int           ks;
        int           budget;

        errors = 0;
        checks = 0;
        edge_n = 0;
        model_reset();
        rst_n = 1'b0;
        bus_o.push = 1'b0; bus_o.wdata = '0; bus_o.pop = 1'b0;
        bus_s.push = 1'b0; bus_s.wdata = '0; bus_s.pop = 1'b0;

        // First-word latency and single-word round trips, both families.
        vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 6'd1, 8'h00};
        vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 6'd1, 8'h00};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 6'd1, 8'hA5};
        vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 6'd1, 8'hA5};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 6'd0, 8'h00};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 6'd0, 8'h00};
        vecs[6]  = '{1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 6'd1, 8'h00};
        vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 6'd1, 8'h00};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 6'd1, 8'h3C};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 6'd1, 8'h3C};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 6'd0, 8'h00};

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_o_empty", 32'(bus_o.empty), 32'd1);
        chk("rst_o_full",  32'(bus_o.full),  32'd0);
        chk("rst_o_used",  32'(bus_o.used),  32'd0);
        chk("rst_s_empty", 32'(bus_s.empty), 32'd1);
        chk("rst_s_used",  32'(bus_s.used),  32'd0);
        rst_n = 1'b1;

        // Table vectors.
        for (int i = 0; i < 11; i++) begin
            step(vecs[i].push, vecs[i].wdata, vecs[i].pop);
            chk("tbl_o_empty", 32'(bus_o.empty), 32'(vecs[i].e_o));
            chk("tbl_s_empty", 32'(bus_s.empty), 32'(vecs[i].e_s));
            chk("tbl_o_used",  32'(bus_o.used),  32'(vecs[i].used));
            chk("tbl_s_used",  32'(bus_s.used),  32'(vecs[i].used));
            chk("tbl_o_full",  32'(bus_o.full),  32'd0);
            if (!vecs[i].e_o) chk("tbl_o_rdata", 32'(bus_o.rdata), 32'(vecs[i].rd));
            if (!vecs[i].e_s) chk("tbl_s_rdata", 32'(bus_s.rdata), 32'(vecs[i].rd));
        end

        // Fill 32 words, then a dropped 33rd push.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0);
        chk("fill_o_full", 32'(bus_o.full), 32'd1);
        chk("fill_s_full", 32'(bus_s.full), 32'd1);
        chk("fill_o_used", 32'(bus_o.used), 32'd32);
        step(1'b1, 8'hFF, 1'b0);
        chk("drop_o_used", 32'(bus_o.used), 32'd32);
        chk("drop_s_used", 32'(bus_s.used), 32'd32);

        // Drain in order.
        ko = 0;
        ks = 0;
        budget = 0;
        while ((ko < DEPTH || ks < DEPTH) && budget < 200) begin
            if (!bus_o.empty && ko < DEPTH) begin
                chk("drain_o", 32'(bus_o.rdata), 32'(ko));
                ko++;
            end
            if (!bus_s.empty && ks < DEPTH) begin
                chk("drain_s", 32'(bus_s.rdata), 32'(ks));
                ks++;
            end
            step(1'b0, 8'h00, 1'b1);
            budget++;
        end
        chk("drain_done", 32'(ko + ks), 32'(2 * DEPTH));
        chk("drain_o_empty", 32'(bus_o.empty), 32'd1);
        chk("drain_s_empty", 32'(bus_s.empty), 32'd1);

        // Push and pop together while full.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(32 + i), 1'b0);
        repeat (4) step(1'b0, 8'h00, 1'b0);
        chk("full_pre_o_rd", 32'(bus_o.rdata), 32'd32);
        step(1'b1, 8'hEE, 1'b1);
        chk("full_pp_o_used", 32'(bus_o.used), 32'd31);
        chk("full_pp_s_used", 32'(bus_s.used), 32'd31);
        chk("full_pp_o_full", 32'(bus_o.full), 32'd0);
        chk("full_pp_o_rd",   32'(bus_o.rdata), 32'd33);
        chk("full_pp_s_rd",   32'(bus_s.rdata), 32'd33);
        repeat (40) step(1'b0, 8'h00, 1'b1);

        // Sustained push+pop after two preloaded words.
        step(1'b1, 8'hFE, 1'b0);
        step(1'b1, 8'hFF, 1'b0);
        prev_o = bus_o.rdata;
        prev_s = bus_s.rdata;
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 8'(i), 1'b1);
            if (i >= 10) begin
                chk("stream_o_empty", 32'(bus_o.empty), 32'd0);
                chk("stream_s_empty", 32'(bus_s.empty), 32'd0);
                chk("stream_o_inc", 32'(bus_o.rdata), 32'(8'(prev_o + 8'd1)));
                chk("stream_s_inc", 32'(bus_s.rdata), 32'(8'(prev_s + 8'd1)));
            end
            prev_o = bus_o.rdata;
            prev_s = bus_s.rdata;
        end
        repeat (10) step(1'b0, 8'h00, 1'b1);

        // Mid-stream asynchronous reset at used=10.
        for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
        repeat (3) step(1'b0, 8'h00, 1'b0);
        chk("pre_rst_o_used", 32'(bus_o.used), 32'd10);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_o_empty", 32'(bus_o.empty), 32'd1);
        chk("arst_o_full",  32'(bus_o.full),  32'd0);
        chk("arst_o_used",  32'(bus_o.used),  32'd0);
        chk("arst_s_empty", 32'(bus_s.empty), 32'd1);
        chk("arst_s_used",  32'(bus_s.used),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 8'h00, 1'b1);
        chk("post_rst_pop", 32'(bus_o.used), 32'd0);
        step(1'b1, 8'h77, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("post_rst_o_rd", 32'(bus_o.rdata), 32'h77);
        step(1'b0, 8'h00, 1'b0);
        chk("post_rst_s_rd", 32'(bus_s.rdata), 32'h77);
        step(1'b0, 8'h00, 1'b1);

        // Random traffic: push-heavy then pop-heavy.
        for (int i = 0; i < 800; i++) begin
            if (i < 400)
                step($urandom_range(0, 99) < 70, 8'($urandom_range(0, 255)), $urandom_range(0, 99) < 40);
            else
                step($urandom_range(0, 99) < 40, 8'($urandom_range(0, 255)), $urandom_range(0, 99) < 75);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
